// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin arbiter: NUM_PORTS AXI4-Stream requesters share one registered output slot.
// state | meaning
// IDLE  | no grant held; next requester is chosen starting at ptr
// GRANT | grant held on one port until its last beat transfers
module stream_rr_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_PORTS   = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            in_last,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_last,
  output logic [INDEX_WIDTH-1:0]          out_index,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic [INDEX_WIDTH-1:0] grant_q, grant_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   last_q, last_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic                   valid_q, valid_d;

  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   sel_last;
  logic                   sel_valid;
  logic [INDEX_WIDTH-1:0] pick;
  logic                   int_ready;
  logic                   xfer;

  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (grant_q == INDEX_WIDTH'(k)) begin
        sel_data  = in_data[k*DATA_WIDTH +: DATA_WIDTH];
        sel_last  = in_last[k];
        sel_valid = in_valid[k];
      end
    end
  end

  // Descending scans: the first finds the lowest requester overall (wrap case),
  // the second overrides it with the lowest requester at or after ptr.
  always_comb begin
    pick = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (in_valid[k]) pick = INDEX_WIDTH'(k);
    end
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (in_valid[k] && (INDEX_WIDTH'(k) >= ptr_q)) pick = INDEX_WIDTH'(k);
    end
  end

  always_comb begin
    int_ready = ~valid_q | out_ready;
    xfer      = (state_q == GRANT) & sel_valid & int_ready;

    in_ready = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (aresetn && (state_q == GRANT) && (grant_q == INDEX_WIDTH'(k))) in_ready[k] = int_ready;
    end

    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    last_d  = last_q;
    index_d = index_q;
    valid_d = valid_q;

    if (int_ready) valid_d = xfer;

    unique case (state_q)
      IDLE: begin
        if (|in_valid) begin
          grant_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          data_d  = sel_data;
          last_d  = sel_last;
          index_d = grant_q;
          if (sel_last) begin
            ptr_d   = (grant_q == INDEX_WIDTH'(NUM_PORTS - 1)) ? '0 : grant_q + INDEX_WIDTH'(1);
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      index_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      last_q  <= last_d;
      index_q <= index_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_index = index_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: directed scenarios followed by randomized traffic.
module tb_stream_rr_arbiter;
  localparam int DW = 32;
  localparam int NP = 4;
  localparam int IW = 2;

  logic aclk = 1'b0;
  logic aresetn;
  logic [NP*DW-1:0] in_data;
  logic [NP-1:0] in_last, in_valid, in_ready;
  logic [DW-1:0] out_data;
  logic out_last, out_valid, out_ready, busy;
  logic [IW-1:0] out_index;

  stream_rr_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .INDEX_WIDTH(IW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_index(out_index),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // stimulus storage: per-port ring of {last, data}
  logic [32:0] pend[NP][64];
  int head[NP];
  int tail[NP];
  int vprob[NP];
  int oprob = 100;
  bit opat[$];
  logic [NP-1:0] acc = '0;

  logic [36:0] exp_q[$];
  int idx_log[$];
  int cyc_log[$];
  int stall_cnt = 0;

  // reference arbitration state
  bit m_busy = 1'b0;
  int m_ptr = 0;
  int m_grant = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load(input int p, input int n, input logic [31:0] base, input bit end_pkt);
    for (int i = 0; i < n; i++) begin
      pend[p][tail[p] % 64] = {(end_pkt && (i == n - 1)), base + 32'(i)};
      tail[p]++;
    end
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int t;
    t = 0;
    while ((idx_log.size() < n) && (t < budget)) begin
      @(negedge aclk); #3;
      t++;
    end
    check({name, "_beats_seen"}, idx_log.size() >= n, 1);
  endtask

  task automatic next_cycle();
    @(negedge aclk); #3;
  endtask

  // driver: hold a beat until it is accepted, then optionally present the next one
  always @(negedge aclk) begin
    if (!aresetn) begin
      in_valid = '0;
      in_last  = '0;
      for (int k = 0; k < NP; k++) head[k] = tail[k];
    end else begin
      for (int k = 0; k < NP; k++) begin
        if (acc[k]) begin
          in_valid[k] = 1'b0;
          in_last[k]  = 1'b0;
          head[k]++;
        end
        if (!in_valid[k] && (head[k] != tail[k]) && ($urandom_range(99) < vprob[k])) begin
          in_valid[k] = 1'b1;
          in_data[k*DW +: DW] = pend[k][head[k] % 64][31:0];
          in_last[k] = pend[k][head[k] % 64][32];
        end
      end
    end
    if (opat.size() > 0) out_ready = opat.pop_front();
    else out_ready = ($urandom_range(99) < oprob);
  end

  // input-side observer: round-robin reference model and expected-beat producer
  always @(negedge aclk) begin : observer
    logic [NP-1:0] exp_rdy;
    bit found;
    int c;
    #1;
    if (!aresetn) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      acc    = '0;
      exp_q.delete();
    end else begin
      exp_rdy = '0;
      if (m_busy && (!out_valid || out_ready)) exp_rdy[m_grant] = 1'b1;
      check("busy", busy, m_busy);
      check("in_ready", in_ready, exp_rdy);
      acc = in_valid & in_ready;
      for (int k = 0; k < NP; k++) begin
        if (acc[k]) exp_q.push_back({4'(k), in_last[k], in_data[k*DW +: DW]});
      end
      if (m_busy) begin
        if (acc[m_grant] && in_last[m_grant]) begin
          m_busy = 1'b0;
          m_ptr  = (m_grant + 1) % NP;
        end
      end else if (|in_valid) begin
        found = 1'b0;
        for (int i = 0; i < NP; i++) begin
          c = (m_ptr + i) % NP;
          if (!found && in_valid[c]) begin
            found   = 1'b1;
            m_grant = c;
          end
        end
        m_busy = 1'b1;
      end
    end
  end

  // output-side monitor: pops the scoreboard on every output handshake
  always @(negedge aclk) begin : monitor
    bit stall;
    bit in_pkt;
    int pkt_idx;
    logic [34:0] held;
    logic [36:0] e;
    #2;
    if (!aresetn) begin
      stall  = 1'b0;
      in_pkt = 1'b0;
    end else begin
      if (stall) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_beat", {out_index, out_last, out_data}, held);
      end
      if (out_valid && out_ready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_beat", {2'b00, out_index, out_last, out_data}, e);
        end
        if (in_pkt) check("no_interleave", out_index, pkt_idx);
        pkt_idx = int'(out_index);
        in_pkt  = !out_last;
        idx_log.push_back(int'(out_index));
        cyc_log.push_back(cyc);
      end
      stall = out_valid && !out_ready;
      if (stall) stall_cnt++;
      held = {out_index, out_last, out_data};
    end
  end

  task automatic apply_reset();
    aresetn = 1'b0;
    repeat (2) next_cycle();
    aresetn = 1'b1;
    next_cycle();
  endtask

  initial begin
    int e2[6];
    int g2[5];
    int e3[3];
    int e6[6];
    int total;
    int t;
    int len;
    aresetn  = 1'b0;
    in_valid = '0;
    in_last  = '0;
    in_data  = '0;
    out_ready = 1'b1;
    for (int k = 0; k < NP; k++) vprob[k] = 100;

    // reset state
    repeat (3) next_cycle();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_index", out_index, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    aresetn = 1'b1;
    next_cycle();

    // single 3-beat packet on port 0: latency and framing
    load(0, 3, 32'hA000_0000, 1'b1);
    next_cycle();
    check("t1_c0_in_ready", in_ready, 4'b0000);
    check("t1_c0_out_valid", out_valid, 0);
    next_cycle();
    check("t1_c1_busy", busy, 1);
    check("t1_c1_in_ready", in_ready, 4'b0001);
    check("t1_c1_out_valid", out_valid, 0);
    next_cycle();
    check("t1_c2_out", {out_valid, out_last, out_index, out_data}, {1'b1, 1'b0, 2'd0, 32'hA000_0000});
    next_cycle();
    check("t1_c3_out", {out_valid, out_last, out_index, out_data}, {1'b1, 1'b0, 2'd0, 32'hA000_0001});
    next_cycle();
    check("t1_c4_out", {out_valid, out_last, out_index, out_data}, {1'b1, 1'b1, 2'd0, 32'hA000_0002});
    check("t1_c4_busy", busy, 0);
    next_cycle();
    check("t1_c5_out_valid", out_valid, 0);

    // ports 0 and 2 with 2-beat packets from reset
    apply_reset();
    idx_log.delete(); cyc_log.delete();
    load(0, 2, 32'hB000_0000, 1'b1);
    load(0, 2, 32'hB000_0010, 1'b1);
    load(2, 2, 32'hB200_0000, 1'b1);
    wait_beats(6, 100, "t2");
    e2 = '{0, 0, 2, 2, 0, 0};
    g2 = '{1, 2, 1, 2, 1};
    for (int i = 0; i < 6; i++) if (i < idx_log.size()) check("t2_index", idx_log[i], e2[i]);
    for (int i = 1; i < 6; i++) if (i < cyc_log.size()) check("t2_gap", cyc_log[i] - cyc_log[i-1], g2[i-1]);

    // port 3 alone, then ports 0 and 3 together: pointer wraps to 0
    idx_log.delete();
    load(3, 1, 32'hC300_0000, 1'b1);
    wait_beats(1, 50, "t3a");
    load(0, 1, 32'hC000_0000, 1'b1);
    load(3, 1, 32'hC300_0001, 1'b1);
    wait_beats(3, 50, "t3b");
    e3 = '{3, 0, 3};
    for (int i = 0; i < 3; i++) if (i < idx_log.size()) check("t3_index", idx_log[i], e3[i]);

    // backpressure pattern during a 4-beat packet
    idx_log.delete();
    stall_cnt = 0;
    opat = '{1, 1, 1, 0, 0, 1, 1, 0, 1};
    load(1, 4, 32'hD100_0000, 1'b1);
    wait_beats(4, 100, "t4");
    check("t4_stalls_seen", stall_cnt > 0, 1);
    for (int i = 0; i < 4; i++) if (i < idx_log.size()) check("t4_index", idx_log[i], 1);

    // reset in the middle of a port-1 packet
    repeat (3) next_cycle();
    idx_log.delete();
    load(1, 5, 32'hE100_0000, 1'b1);
    wait_beats(2, 50, "t5a");
    aresetn = 1'b0;
    #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_in_ready", in_ready, 0);
    check("t5_rst_busy", busy, 0);
    next_cycle();
    aresetn = 1'b1;
    next_cycle();
    idx_log.delete();
    load(2, 1, 32'hE200_0000, 1'b1);
    load(0, 1, 32'hE000_0000, 1'b1);
    wait_beats(2, 50, "t5b");
    if (idx_log.size() >= 2) begin
      check("t5_first_after_reset", idx_log[0], 0);
      check("t5_second_after_reset", idx_log[1], 2);
    end

    // granted port stalls mid-packet while port 0 requests
    repeat (2) next_cycle();
    idx_log.delete();
    load(1, 2, 32'hF100_0000, 1'b0);
    wait_beats(2, 50, "t6a");
    load(0, 1, 32'hF000_0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("t6_busy_held", busy, 1);
      check("t6_port0_blocked", in_ready[0], 0);
    end
    load(1, 3, 32'hF100_0002, 1'b1);
    wait_beats(6, 50, "t6b");
    e6 = '{1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 6; i++) if (i < idx_log.size()) check("t6_index", idx_log[i], e6[i]);

    // randomized traffic against the reference model
    repeat (2) next_cycle();
    idx_log.delete();
    total = 0;
    for (int k = 0; k < NP; k++) begin
      vprob[k] = $urandom_range(30, 90);
      for (int p = 0; p < 8; p++) begin
        len = $urandom_range(1, 4);
        load(k, len, $urandom, 1'b1);
        total += len;
      end
    end
    oprob = 70;
    t = 0;
    while (t < 4000) begin
      next_cycle();
      t++;
      if ((idx_log.size() >= total) && (exp_q.size() == 0)) break;
    end
    oprob = 100;
    repeat (3) next_cycle();
    check("rand_beat_count", idx_log.size(), total);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
